// File: rtl/mips_cpu_run_monitor.sv
// Run monitor for the MIPS Harvard CPU benches: checks the reset vector, counts cycles and
// fetches up to halt, waits for the CPU to go idle, then latches a sticky pass/fail verdict.
module mips_cpu_run_monitor #(
  parameter int unsigned             ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]       RESET_VECTOR = 32'hBFC00000,
  parameter logic [ADDR_W-1:0]       HALT_ADDR    = 32'h00000000,
  parameter int unsigned             CNT_W        = 16,
  parameter int unsigned             TIMEOUT      = 1000,
  parameter int unsigned             DRAIN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  input  logic              active,
  input  logic [ADDR_W-1:0] instr_address,
  input  logic [ADDR_W-1:0] register_v0,
  input  logic [ADDR_W-1:0] expected_v0,
  output logic              done,
  output logic              pass,
  output logic [2:0]        fail_code,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  fetch_count,
  output logic [ADDR_W-1:0] v0_captured
);

  localparam int unsigned DrainW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StRun, StDrain, StPass, StFail} state_e;

  state_e              state_q, state_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [2:0]          fail_code_q, fail_code_d;
  logic [CNT_W-1:0]    cycle_q, cycle_d;
  logic [CNT_W-1:0]    fetch_q, fetch_d;
  logic [ADDR_W-1:0]   v0_q, v0_d;
  logic [ADDR_W-1:0]   exp_q, exp_d;
  logic [ADDR_W-1:0]   prev_q, prev_d;
  logic [DrainW-1:0]   drain_q, drain_d;

  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_code_d = fail_code_q;
    cycle_d     = cycle_q;
    fetch_d     = fetch_q;
    v0_d        = v0_q;
    exp_d       = exp_q;
    prev_d      = prev_q;
    drain_d     = drain_q;

    if (clk_enable) begin
      unique case (state_q)
        StIdle: begin
          if (instr_address != RESET_VECTOR) begin
            state_d     = StFail;
            done_d      = 1'b1;
            fail_code_d = 3'd1;
          end else begin
            state_d = StRun;
            cycle_d = CNT_W'(1);
            prev_d  = instr_address;
          end
        end
        StRun: begin
          cycle_d = cycle_q + CNT_W'(1);
          if (instr_address != prev_q) begin
            fetch_d = fetch_q + CNT_W'(1);
            prev_d  = instr_address;
          end
          // Halt beats timeout when both land on the same cycle.
          if (instr_address == HALT_ADDR) begin
            v0_d    = register_v0;
            exp_d   = expected_v0;
            drain_d = '0;
            state_d = StDrain;
          end else if (cycle_d == CNT_W'(TIMEOUT)) begin
            state_d     = StFail;
            done_d      = 1'b1;
            fail_code_d = 3'd2;
          end
        end
        StDrain: begin
          if (!active) begin
            done_d = 1'b1;
            if (v0_q == exp_q) begin
              state_d     = StPass;
              pass_d      = 1'b1;
              fail_code_d = 3'd0;
            end else begin
              state_d     = StFail;
              fail_code_d = 3'd4;
            end
          end else begin
            drain_d = drain_q + DrainW'(1);
            if (drain_d == DrainW'(DRAIN_CYCLES)) begin
              state_d     = StFail;
              done_d      = 1'b1;
              fail_code_d = 3'd3;
            end
          end
        end
        StPass, StFail: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_code_q <= 3'd0;
      cycle_q     <= '0;
      fetch_q     <= '0;
      v0_q        <= '0;
      exp_q       <= '0;
      prev_q      <= '0;
      drain_q     <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_code_q <= fail_code_d;
      cycle_q     <= cycle_d;
      fetch_q     <= fetch_d;
      v0_q        <= v0_d;
      exp_q       <= exp_d;
      prev_q      <= prev_d;
      drain_q     <= drain_d;
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_code   = fail_code_q;
  assign cycle_count = cycle_q;
  assign fetch_count = fetch_q;
  assign v0_captured = v0_q;

endmodule

// File: tb/tb_mips_cpu_run_monitor.sv
// Directed bench for mips_cpu_run_monitor: expected verdicts are queued per run and compared
// once the monitor reports done.
module tb_mips_cpu_run_monitor;

  localparam logic [31:0] RV   = 32'hBFC00000;
  localparam logic [31:0] HALT = 32'h00000000;

  logic        clk = 1'b0;
  logic        reset, clk_enable, active;
  logic [31:0] instr_address, register_v0, expected_v0;
  logic        done, pass;
  logic [2:0]  fail_code;
  logic [15:0] cycle_count, fetch_count;
  logic [31:0] v0_captured;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        done;
    logic        pass;
    logic [2:0]  code;
    logic [15:0] cycles;
    logic [15:0] fetches;
    logic [31:0] v0;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mips_cpu_run_monitor #(
    .ADDR_W      (32),
    .RESET_VECTOR(RV),
    .HALT_ADDR   (HALT),
    .CNT_W       (16),
    .TIMEOUT     (20),
    .DRAIN_CYCLES(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_enable   (clk_enable),
    .active       (active),
    .instr_address(instr_address),
    .register_v0  (register_v0),
    .expected_v0  (expected_v0),
    .done         (done),
    .pass         (pass),
    .fail_code    (fail_code),
    .cycle_count  (cycle_count),
    .fetch_count  (fetch_count),
    .v0_captured  (v0_captured)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic d, input logic p, input logic [2:0] c, input logic [15:0] cy,
                      input logic [15:0] f, input logic [31:0] v);
    exp_t e;
    e.done = d; e.pass = p; e.code = c; e.cycles = cy; e.fetches = f; e.v0 = v;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [31:0] addr, input logic act);
    instr_address = addr;
    active        = act;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Bounded wait for a verdict, then compare it with the oldest queued expectation.
  task automatic finish_run(input string tag);
    exp_t e;
    int   n = 0;
    while (!done && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_done"},  32'(done),        32'(e.done));
      check({tag, "_pass"},  32'(pass),        32'(e.pass));
      check({tag, "_code"},  32'(fail_code),   32'(e.code));
      check({tag, "_cycle"}, 32'(cycle_count), 32'(e.cycles));
      check({tag, "_fetch"}, 32'(fetch_count), 32'(e.fetches));
      check({tag, "_v0"},    v0_captured,      e.v0);
    end
  endtask

  task automatic good_run(input string tag);
    register_v0 = 32'd7;
    expected_v0 = 32'd7;
    push(1'b1, 1'b1, 3'd0, 16'd5, 16'd4, 32'd7);
    drive(RV, 1'b1);
    drive(RV + 32'd4, 1'b1);
    drive(RV + 32'd8, 1'b1);
    drive(RV + 32'd12, 1'b1);
    drive(HALT, 1'b1);
    drive(HALT, 1'b0);
    finish_run(tag);
  endtask

  initial begin
    reset = 1'b0; clk_enable = 1'b1; active = 1'b0;
    instr_address = RV; register_v0 = '0; expected_v0 = '0;

    do_reset();
    check("rst_done",  32'(done), 32'd0);
    check("rst_code",  32'(fail_code), 32'd0);
    check("rst_cycle", 32'(cycle_count), 32'd0);

    // Clean run, v0 matches.
    good_run("pass_run");

    // v0 mismatch; expected_v0 changing after halt must not rescue it.
    do_reset();
    register_v0 = 32'd7;
    expected_v0 = 32'd6;
    push(1'b1, 1'b0, 3'd4, 16'd5, 16'd4, 32'd7);
    drive(RV, 1'b1);
    drive(RV + 32'd4, 1'b1);
    drive(RV + 32'd8, 1'b1);
    drive(RV + 32'd12, 1'b1);
    drive(HALT, 1'b1);
    expected_v0 = 32'd7;
    drive(HALT, 1'b0);
    finish_run("wrong_v0");

    // Bad reset vector.
    do_reset();
    push(1'b1, 1'b0, 3'd1, 16'd0, 16'd0, 32'd0);
    drive(RV + 32'd4, 1'b1);
    check("badvec_first_edge", 32'(done), 32'd1);
    finish_run("bad_vector");

    // Timeout exactly at cycle 20.
    do_reset();
    push(1'b1, 1'b0, 3'd2, 16'd20, 16'd0, 32'd0);
    for (int i = 0; i < 19; i++) drive(RV, 1'b1);
    check("timeout_c19_done", 32'(done), 32'd0);
    drive(RV, 1'b1);
    check("timeout_c20_done", 32'(done), 32'd1);
    finish_run("timeout");

    // Halt on cycle 20 wins over timeout.
    do_reset();
    register_v0 = 32'd9;
    expected_v0 = 32'd9;
    push(1'b1, 1'b1, 3'd0, 16'd20, 16'd1, 32'd9);
    for (int i = 0; i < 19; i++) drive(RV, 1'b1);
    drive(HALT, 1'b1);
    check("halt_c20_done", 32'(done), 32'd0);
    drive(HALT, 1'b0);
    finish_run("halt_at_timeout");

    // Active stuck high after halt.
    do_reset();
    register_v0 = 32'd1;
    expected_v0 = 32'd1;
    push(1'b1, 1'b0, 3'd3, 16'd3, 16'd2, 32'd1);
    drive(RV, 1'b1);
    drive(RV + 32'd4, 1'b1);
    drive(HALT, 1'b1);
    for (int i = 0; i < 3; i++) drive(HALT, 1'b1);
    check("stuck_3_done", 32'(done), 32'd0);
    drive(HALT, 1'b1);
    check("stuck_4_done", 32'(done), 32'd1);
    finish_run("active_stuck");

    // Clock-enable freeze mid-run.
    do_reset();
    register_v0 = 32'd7;
    expected_v0 = 32'd7;
    push(1'b1, 1'b1, 3'd0, 16'd5, 16'd4, 32'd7);
    drive(RV, 1'b1);
    drive(RV + 32'd4, 1'b1);
    clk_enable = 1'b0;
    for (int i = 0; i < 10; i++) drive(HALT, 1'b0);
    check("freeze_cycle", 32'(cycle_count), 32'd2);
    check("freeze_fetch", 32'(fetch_count), 32'd1);
    check("freeze_done",  32'(done), 32'd0);
    clk_enable = 1'b1;
    drive(RV + 32'd8, 1'b1);
    drive(RV + 32'd12, 1'b1);
    drive(HALT, 1'b1);
    drive(HALT, 1'b0);
    finish_run("freeze_run");

    // Reset after a verdict clears everything; a fresh run passes again.
    do_reset();
    check("rst2_done",  32'(done), 32'd0);
    check("rst2_pass",  32'(pass), 32'd0);
    check("rst2_cycle", 32'(cycle_count), 32'd0);
    check("rst2_fetch", 32'(fetch_count), 32'd0);
    check("rst2_v0",    v0_captured, 32'd0);
    good_run("rerun");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
